// File: rtl/rhythm_input_gate.sv
`default_nettype none
// ============================================================================
//  Module   : rhythm_input_gate
//  Purpose  : Input conditioner for the player-animation FSM. Debounces the
//             HID J/K keycodes, tracks the beat phase, qualifies each J press
//             as on-beat (hit) or off-beat (miss), drives PunchEN and keeps a
//             consecutive-hit combo count.
//  Ports    : Clk, Reset (sync, active-high), tick (frame strobe),
//             keycode[7:0] -> J_Press, K_Press, PunchEN, beat, hit, miss,
//             combo[7:0]
//  Config   : RHYTHM_COMBO_EN - defined: combo counter present;
//             undefined: combo tied to 8'd0.
//  Revision : 1.0 - initial release
// ============================================================================
module rhythm_input_gate #(
   parameter int BEAT_TICKS = 30,
   parameter int WINDOW     = 4,
   parameter int DEB_TICKS  = 2
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       tick,
   input  logic [7:0] keycode,
   output logic       J_Press,
   output logic       K_Press,
   output logic       PunchEN,
   output logic       beat,
   output logic       hit,
   output logic       miss,
   output logic [7:0] combo
);

   localparam int         c_cw     = $clog2(DEB_TICKS + 1);
   localparam logic [c_cw-1:0] c_deb_last = c_cw'(DEB_TICKS - 1);
   localparam logic [7:0] c_key_j  = 8'h0D;
   localparam logic [7:0] c_key_k  = 8'h0E;
   localparam logic [7:0] c_last   = 8'(BEAT_TICKS - 1);
   localparam logic [7:0] c_win    = 8'(WINDOW);
   localparam logic [7:0] c_open   = 8'(BEAT_TICKS - WINDOW);

   logic [c_cw-1:0] r_jcnt, r_kcnt, w_jcnt_nxt, w_kcnt_nxt;
   logic            r_jfilt, r_kfilt, w_jfilt_nxt, w_kfilt_nxt;
   logic [7:0]      r_phase;
   logic            r_hitflag, r_punch, r_beat, r_hit, r_miss;
   logic            w_raw_j, w_raw_k, w_inwin, w_close, w_jrise, w_hit, w_miss;

   // Returns {filtered_next, counter_next}. Only called when tick is high.
   function automatic logic [c_cw:0] deb_step(input logic raw, input logic filt,
                                               input logic [c_cw-1:0] cnt);
      logic            f;
      logic [c_cw-1:0] c;
      f = filt;
      c = '0;
      if (raw != filt) begin
         if (cnt == c_deb_last) begin
            f = raw;
         end else begin
            c = cnt + 1'b1;
         end
      end
      return {f, c};
   endfunction

   assign w_raw_j = (keycode == c_key_j);
   assign w_raw_k = (keycode == c_key_k);

   always_comb begin
      {w_jfilt_nxt, w_jcnt_nxt} = {r_jfilt, r_jcnt};
      {w_kfilt_nxt, w_kcnt_nxt} = {r_kfilt, r_kcnt};
      if (tick) begin
         {w_jfilt_nxt, w_jcnt_nxt} = deb_step(w_raw_j, r_jfilt, r_jcnt);
         {w_kfilt_nxt, w_kcnt_nxt} = deb_step(w_raw_k, r_kfilt, r_kcnt);
      end
   end

   // Window and press qualification use the phase before this tick's increment.
   assign w_inwin = (r_phase <= c_win) || (r_phase >= c_open);
   assign w_close = tick && (r_phase == c_win);
   assign w_jrise = ~r_jfilt & w_jfilt_nxt;
   assign w_hit   = w_jrise & w_inwin & ~r_hitflag;
   // A hit landing on the close tick fills the window, so no empty-window miss.
   assign w_miss  = (w_jrise & ~w_hit) | (w_close & ~r_hitflag & ~w_hit);

   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_jcnt    <= '0;
         r_kcnt    <= '0;
         r_jfilt   <= 1'b0;
         r_kfilt   <= 1'b0;
         r_phase   <= 8'd0;
         r_hitflag <= 1'b0;
         r_punch   <= 1'b0;
         r_beat    <= 1'b0;
         r_hit     <= 1'b0;
         r_miss    <= 1'b0;
      end else begin
         r_jcnt  <= w_jcnt_nxt;
         r_kcnt  <= w_kcnt_nxt;
         r_jfilt <= w_jfilt_nxt;
         r_kfilt <= w_kfilt_nxt;
         r_hit   <= w_hit;
         r_miss  <= w_miss;
         r_beat  <= 1'b0;
         if (tick) begin
            if (r_phase == c_last) begin
               r_phase <= 8'd0;
               r_beat  <= 1'b1;
            end else begin
               r_phase <= r_phase + 8'd1;
            end
            if (w_close) begin
               r_hitflag <= 1'b0;
            end else if (w_hit) begin
               r_hitflag <= 1'b1;
            end
         end
         // PunchEN follows the qualification on a rise and drops with J.
         if (w_jrise) begin
            r_punch <= w_hit;
         end else begin
            r_punch <= r_punch & w_jfilt_nxt;
         end
      end
   end

`ifdef RHYTHM_COMBO_EN
   logic [7:0] r_combo;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_combo <= 8'd0;
      end else if (w_miss) begin
         r_combo <= 8'd0;
      end else if (w_hit && (r_combo != 8'hFF)) begin
         r_combo <= r_combo + 8'd1;
      end
   end

   assign combo = r_combo;
`else
   assign combo = 8'd0;
`endif

   assign J_Press = r_jfilt;
   assign K_Press = r_kfilt;
   assign PunchEN = r_punch;
   assign beat    = r_beat;
   assign hit     = r_hit;
   assign miss    = r_miss;

endmodule
`default_nettype wire
